// File: rtl/mmu_engine.sv
// ---------------------------------------------------------------------------
// mmu_engine
//
// Purpose:
//   Computes the 2x2 signed matrix product C = A x W on a small
//   output-stationary systolic array of four MAC processing elements. On a
//   start request in IDLE the eight operand bytes are latched, so later
//   changes on the memory side cannot disturb the job. The four results are
//   then streamed out in row-major order over a valid/ready port, and a
//   one-cycle done pulse follows the last transfer.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset (abandons any job)
//   start               job request, only looked at while IDLE
//   mat_1..mat_4        A00, A01, A10, A11 (signed, DATA_W)
//   weight_1..weight_4  W00, W01, W10, W11 (signed, DATA_W)
//   busy                high in every state except IDLE
//   done                one-cycle pulse after the last result transfers
//   out_valid           out_data / out_idx hold a result
//   out_ready           consumer accepts when high together with out_valid
//   out_data            saturated signed result (ACC_W)
//   out_idx             result index: 0=C00, 1=C01, 2=C10, 3=C11
//
// Configuration:
//   MMU_ENGINE_RELU_EN  when defined, negative saturated results are
//                       output as zero (no extra latency).
// ---------------------------------------------------------------------------
module mmu_engine #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] mat_1,
   input  logic [DATA_W-1:0] mat_2,
   input  logic [DATA_W-1:0] mat_3,
   input  logic [DATA_W-1:0] mat_4,
   input  logic [DATA_W-1:0] weight_1,
   input  logic [DATA_W-1:0] weight_2,
   input  logic [DATA_W-1:0] weight_3,
   input  logic [DATA_W-1:0] weight_4,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic [1:0]        out_idx
);

   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      OUTPUT,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // Compute-phase time step t = 0..3.
   logic [1:0] t_cnt;

   // Operand latches, indexed [row][col].
   logic signed [DATA_W-1:0] a_lat [2][2];
   logic signed [DATA_W-1:0] w_lat [2][2];

   // Skew registers: a_skew[i] carries the A value PE(i,0) used last cycle
   // rightwards into PE(i,1); w_skew[j] carries the W value PE(0,j) used
   // last cycle downwards into PE(1,j). The right column and bottom row
   // have no neighbour to forward to, so they keep no pass registers.
   logic signed [DATA_W-1:0] a_skew [2];
   logic signed [DATA_W-1:0] w_skew [2];

   // Output-stationary accumulators, one guard bit above ACC_W.
   logic signed [ACC_W:0] acc [2][2];

   // Edge feeds into the array and per-PE operands for this cycle.
   logic signed [DATA_W-1:0] left_feed [2];
   logic signed [DATA_W-1:0] top_feed  [2];
   logic signed [DATA_W-1:0] pe_a      [2][2];
   logic signed [DATA_W-1:0] pe_w      [2][2];
   logic signed [PROD_W-1:0] pe_prod   [2][2];
   logic signed [ACC_W:0]    acc_next  [2][2];

   logic                     transfer;
   logic signed [ACC_W:0]    acc_sel;
   logic [ACC_W-1:0]         sat_value;
   logic [ACC_W-1:0]         result_value;

   assign transfer = out_valid & out_ready;

   // State register; reset abandons whatever job is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status outputs. Start is only honoured in IDLE, so
   // requests during COMPUTE, OUTPUT or DONE are simply dropped.
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = COMPUTE;
            end
         end
         COMPUTE: begin
            if (t_cnt == 2'd3) begin
               state_next = OUTPUT;
            end
         end
         OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready && (out_idx == 2'd3)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Boundary feeds: row i sees A[i][t-i] and column j sees W[t-j][j] while
   // that index is 0 or 1, and zero otherwise, which produces the diagonal
   // wavefront so that PE(i,j) meets A[i][k] and W[k][j] at t = i+j+k.
   always_comb begin
      left_feed[0] = '0;
      left_feed[1] = '0;
      top_feed[0]  = '0;
      top_feed[1]  = '0;
      case (t_cnt)
         2'd0: begin
            left_feed[0] = a_lat[0][0];
            top_feed[0]  = w_lat[0][0];
         end
         2'd1: begin
            left_feed[0] = a_lat[0][1];
            left_feed[1] = a_lat[1][0];
            top_feed[0]  = w_lat[1][0];
            top_feed[1]  = w_lat[0][1];
         end
         2'd2: begin
            left_feed[1] = a_lat[1][1];
            top_feed[1]  = w_lat[1][1];
         end
         default: begin
         end
      endcase
   end

   // PE interconnect and MAC arithmetic. Operands are widened to the full
   // product width before multiplying so the product is an exact signed
   // value, then sign-extended into the accumulator.
   always_comb begin
      pe_a[0][0] = left_feed[0];
      pe_a[0][1] = a_skew[0];
      pe_a[1][0] = left_feed[1];
      pe_a[1][1] = a_skew[1];
      pe_w[0][0] = top_feed[0];
      pe_w[0][1] = top_feed[1];
      pe_w[1][0] = w_skew[0];
      pe_w[1][1] = w_skew[1];
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            pe_prod[i][j]  = PROD_W'(pe_a[i][j]) * PROD_W'(pe_w[i][j]);
            acc_next[i][j] = acc[i][j] + (ACC_W+1)'(pe_prod[i][j]);
         end
      end
   end

   // Datapath registers: operand latch on accept, array stepping during
   // COMPUTE, and the result index walking forward on each transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         t_cnt   <= '0;
         out_idx <= '0;
         for (int i = 0; i < 2; i++) begin
            a_skew[i] <= '0;
            w_skew[i] <= '0;
            for (int j = 0; j < 2; j++) begin
               a_lat[i][j] <= '0;
               w_lat[i][j] <= '0;
               acc[i][j]   <= '0;
            end
         end
      end else begin
         case (state)
            IDLE: begin
               out_idx <= '0;
               if (start) begin
                  t_cnt       <= '0;
                  a_lat[0][0] <= mat_1;
                  a_lat[0][1] <= mat_2;
                  a_lat[1][0] <= mat_3;
                  a_lat[1][1] <= mat_4;
                  w_lat[0][0] <= weight_1;
                  w_lat[0][1] <= weight_2;
                  w_lat[1][0] <= weight_3;
                  w_lat[1][1] <= weight_4;
                  for (int i = 0; i < 2; i++) begin
                     a_skew[i] <= '0;
                     w_skew[i] <= '0;
                     for (int j = 0; j < 2; j++) begin
                        acc[i][j] <= '0;
                     end
                  end
               end
            end
            COMPUTE: begin
               t_cnt     <= t_cnt + 2'd1;
               a_skew[0] <= pe_a[0][0];
               a_skew[1] <= pe_a[1][0];
               w_skew[0] <= pe_w[0][0];
               w_skew[1] <= pe_w[0][1];
               for (int i = 0; i < 2; i++) begin
                  for (int j = 0; j < 2; j++) begin
                     acc[i][j] <= acc_next[i][j];
                  end
               end
            end
            OUTPUT: begin
               if (transfer) begin
                  out_idx <= out_idx + 2'd1;
               end
            end
            DONE: begin
               out_idx <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // Result selection and saturation. The accumulator carries one guard
   // bit, so overflow shows up as the top two bits disagreeing; the sign
   // bit then tells which rail to clamp to.
   always_comb begin
      acc_sel = acc[out_idx[1]][out_idx[0]];
      if (acc_sel[ACC_W] != acc_sel[ACC_W-1]) begin
         if (acc_sel[ACC_W]) begin
            sat_value = {1'b1, {(ACC_W-1){1'b0}}};
         end else begin
            sat_value = {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else begin
         sat_value = acc_sel[ACC_W-1:0];
      end
`ifdef MMU_ENGINE_RELU_EN
      if (sat_value[ACC_W-1]) begin
         result_value = '0;
      end else begin
         result_value = sat_value;
      end
`else
      result_value = sat_value;
`endif
   end

   // out_data is driven only while a result is being offered, otherwise 0.
   always_comb begin
      out_data = '0;
      if (state == OUTPUT) begin
         out_data = result_value;
      end
   end

endmodule

// File: tb/tb_mmu_engine.sv
// ---------------------------------------------------------------------------
// tb_mmu_engine
//
// Self-checking bench for mmu_engine. Each job is compared against a plain
// integer matrix-multiply model with saturation (and ReLU when
// MMU_ENGINE_RELU_EN is defined). Inputs are driven and outputs sampled on
// the falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_mmu_engine;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;

   logic              clk;
   logic              rst;
   logic              start;
   logic [DATA_W-1:0] mat_1, mat_2, mat_3, mat_4;
   logic [DATA_W-1:0] weight_1, weight_2, weight_3, weight_4;
   logic              busy;
   logic              done;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic [1:0]        out_idx;

   int checkCount;
   int errorCount;

   mmu_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mat_1     (mat_1),
      .mat_2     (mat_2),
      .mat_3     (mat_3),
      .mat_4     (mat_4),
      .weight_1  (weight_1),
      .weight_2  (weight_2),
      .weight_3  (weight_3),
      .weight_4  (weight_4),
      .busy      (busy),
      .done      (done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung DUT handshake.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h required %0h", tag, observed, expected);
      end
   endtask

   // Reference: C[i][j] = sum over k of A[i][k]*W[k][j], clamped to the
   // signed ACC_W range, then optionally ReLU'd.
   function automatic logic [ACC_W-1:0] modelResult(input int a[4], input int w[4],
                                                    input int idx);
      int i;
      int j;
      int s;
      int maxV;
      int minV;
      i    = idx / 2;
      j    = idx % 2;
      s    = a[2*i] * w[j] + a[2*i+1] * w[2+j];
      maxV = (1 << (ACC_W-1)) - 1;
      minV = -(1 << (ACC_W-1));
      if (s > maxV) s = maxV;
      if (s < minV) s = minV;
`ifdef MMU_ENGINE_RELU_EN
      if (s < 0) s = 0;
`endif
      return ACC_W'(s);
   endfunction

   function automatic int randByte();
      int v;
      v = int'($urandom_range(0, 255));
      if (v > 127) v -= 256;
      return v;
   endfunction

   task automatic driveOperands(input int a[4], input int w[4]);
      mat_1    = DATA_W'(a[0]);
      mat_2    = DATA_W'(a[1]);
      mat_3    = DATA_W'(a[2]);
      mat_4    = DATA_W'(a[3]);
      weight_1 = DATA_W'(w[0]);
      weight_2 = DATA_W'(w[1]);
      weight_3 = DATA_W'(w[2]);
      weight_4 = DATA_W'(w[3]);
   endtask

   task automatic scrambleOperands();
      mat_1    = DATA_W'($urandom);
      mat_2    = DATA_W'($urandom);
      mat_3    = DATA_W'($urandom);
      mat_4    = DATA_W'($urandom);
      weight_1 = DATA_W'($urandom);
      weight_2 = DATA_W'($urandom);
      weight_3 = DATA_W'($urandom);
      weight_4 = DATA_W'($urandom);
   endtask

   // Runs one complete job; called at a falling edge with the DUT idle.
   // stallMode < 0 picks a random stall of 0..2 cycles per result, else a
   // fixed stall. scramble changes the operand pins after accept; poke
   // raises start during COMPUTE, OUTPUT and DONE, all of which must be
   // ignored.
   task automatic applyStimulus(input int a[4], input int w[4], input int stallMode,
                                input bit scramble, input bit poke);
      int               lat;
      bit               seen;
      int               nStall;
      logic [ACC_W-1:0] exp;
      driveOperands(a, w);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_accept", 32'(busy), 32'd1);
      if (scramble) scrambleOperands();
      lat  = 0;
      seen = 1'b0;
      for (int c = 1; c <= 12 && !seen; c++) begin
         start = (poke && c == 2);
         @(negedge clk);
         lat  = c;
         seen = out_valid;
      end
      start = 1'b0;
      checkOutput("first_valid_latency", seen ? 32'(lat) : 32'd999, 32'd4);
      if (!seen) return;
      for (int idx = 0; idx < 4; idx++) begin
         exp    = modelResult(a, w, idx);
         nStall = (stallMode < 0) ? int'($urandom_range(0, 2)) : stallMode;
         out_ready = 1'b0;
         for (int s = 0; s < nStall; s++) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_idx", 32'(out_idx), 32'(idx));
            checkOutput("stall_data", 32'(out_data), 32'(exp));
            @(negedge clk);
         end
         out_ready = 1'b1;
         if (poke && idx == 2) start = 1'b1;
         checkOutput("out_valid", 32'(out_valid), 32'd1);
         checkOutput("out_idx", 32'(out_idx), 32'(idx));
         checkOutput("out_data", 32'(out_data), 32'(exp));
         checkOutput("done_low_during_output", 32'(done), 32'd0);
         @(negedge clk);
         start = 1'b0;
      end
      out_ready = 1'b0;
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("busy_in_done", 32'(busy), 32'd1);
      checkOutput("valid_after_last", 32'(out_valid), 32'd0);
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("idx_back_to_zero", 32'(out_idx), 32'd0);
      if (poke) begin
         @(negedge clk);
         checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int a[4];
      int w[4];
      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      start      = 1'b0;
      out_ready  = 1'b0;
      a = '{0, 0, 0, 0};
      w = '{0, 0, 0, 0};
      driveOperands(a, w);

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_data", 32'(out_data), 32'd0);
      checkOutput("reset_idx", 32'(out_idx), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] basic product");
      a = '{1, 2, 3, 4};
      w = '{5, 6, 7, 8};
      applyStimulus(a, w, 0, 1'b0, 1'b0);
      checkOutput("basic_model_c00", 32'(modelResult(a, w, 0)), 32'd19);

      $display("[TB] signed values");
      a = '{-1, 2, 3, -4};
      w = '{1, 0, 0, 1};
      applyStimulus(a, w, 0, 1'b0, 1'b0);

      $display("[TB] saturation");
      a = '{-128, -128, -128, -128};
      w = '{-128, -128, -128, -128};
      applyStimulus(a, w, 0, 1'b0, 1'b0);

      $display("[TB] backpressure with operand changes");
      a = '{1, 2, 3, 4};
      w = '{5, 6, 7, 8};
      applyStimulus(a, w, 3, 1'b1, 1'b0);

      $display("[TB] start while busy");
      a = '{7, -3, 11, 2};
      w = '{-5, 9, 4, -6};
      applyStimulus(a, w, 1, 1'b1, 1'b1);
      a = '{2, 1, -1, 3};
      w = '{4, 4, -2, 5};
      applyStimulus(a, w, 0, 1'b0, 1'b0);

      $display("[TB] reset mid-operation");
      a = '{1, 2, 3, 4};
      w = '{5, 6, 7, 8};
      driveOperands(a, w);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("pre_reset_idx", 32'(out_idx), 32'd1);
      rst       = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_done", 32'(done), 32'd0);
      checkOutput("midreset_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset_data", 32'(out_data), 32'd0);
      checkOutput("midreset_idx", 32'(out_idx), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      a = '{1, 0, 0, 1};
      w = '{2, 3, 4, 5};
      applyStimulus(a, w, 0, 1'b0, 1'b0);

      $display("[TB] randomized jobs");
      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < 4; k++) begin
            a[k] = ($urandom_range(0, 7) == 0) ? -128 : randByte();
            w[k] = ($urandom_range(0, 7) == 0) ? -128 : randByte();
         end
         applyStimulus(a, w, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
